// File: rtl/cva6_ras_circular.sv
// Circular return-address stack with occupancy tracking, overflow pulse,
// replace-on-push+pop and speculative flush. Works for any DEPTH >= 1.
module cva6_ras_circular #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned VLEN  = 32,
  parameter int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [VLEN-1:0]  data_i,
  output logic             valid_o,
  output logic [VLEN-1:0]  ra_o,
  output logic [PTR_W:0]   count_o,
  output logic             overflow_o
);

  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);

  logic [VLEN-1:0]  entry_q [DEPTH];
  logic [PTR_W-1:0] tp_q, tp_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;

  // Explicit wrap compares so non-power-of-2 depths never rely on modulo overflow.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PTR_ONE;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? LAST_IDX : p - PTR_ONE;
  endfunction

  always_comb begin
    tp_d    = tp_q;
    count_d = count_q;
    ovf_d   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = tp_q;
    if (flush_i) begin
      tp_d    = '0;
      count_d = '0;
    end else if (push_i && pop_i && (count_q != '0)) begin
      wr_en  = 1'b1;
      wr_idx = tp_q;
    end else if (push_i) begin
      tp_d   = ptr_inc(tp_q);
      wr_en  = 1'b1;
      wr_idx = ptr_inc(tp_q);
      if (count_q == CNT_FULL) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + CNT_ONE;
      end
    end else if (pop_i && (count_q != '0)) begin
      tp_d    = ptr_dec(tp_q);
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      tp_q    <= tp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en && (wr_idx == PTR_W'(i))) begin
          entry_q[i] <= data_i;
        end
      end
    end
  end

  always_comb begin
    ra_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tp_q == PTR_W'(i)) begin
        ra_o = entry_q[i];
      end
    end
  end

  assign valid_o    = (count_q != '0);
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule

// File: doc/cva6_ras_circular.md
Name: cva6_ras_circular

Overview:
- Parametrised return-address stack (RAS) for the frontend branch predictor.
- Generalises the fixed-depth shift-register RAS:
  - circular storage of any depth, including non-power-of-2
  - occupancy tracking
  - overflow signalling
  - defined simultaneous push/pop (replace) semantics
  - speculative flush
- Depth is taken from the core configuration's RASDepth; address width from XLEN/VLEN.

Parameters:
- DEPTH, 2, number of RAS entries; legal range ≥1, any integer.
- VLEN, 32, width of a stored return address in bits.
- PTR_W, $clog2(DEPTH) (min 1), derived pointer width; not overridden.

Ports:
- clk_i  input  1  core clock, rising-edge.
- rst_ni  input  1  asynchronous active-low reset.
- flush_i  input  1  discard all entries (mispredict / fence.i recovery).
- push_i  input  1  push data_i (call instruction predicted).
- pop_i  input  1  pop top entry (return instruction predicted).
- data_i  input  VLEN  return address to push.
- valid_o  output  1  stack non-empty; ra_o is meaningful.
- ra_o  output  VLEN  current top-of-stack address.
- count_o  output  PTR_W+1  number of valid entries, 0..DEPTH.
- overflow_o  output  1  one-cycle registered pulse: previous cycle's push overwrote the oldest entry.

Behaviour:
- Reset (rst_ni low, asynchronous) values:
  - all entries = 0; top pointer tp = 0; count = 0
  - valid_o = 0; ra_o = 0; count_o = 0; overflow_o = 0
  - Reset asserted mid-operation discards everything immediately.
- Storage: entry[0..DEPTH-1] registers; tp indexes the top. All state updates on the rising clk_i edge.
- Output timing:
  - ra_o = entry[tp] and valid_o = (count != 0), combinational from registered state only; no input-to-output path.
  - A push is visible on ra_o the cycle after it is accepted.
- Pointer arithmetic:
  - increment: tp = (tp == DEPTH-1) ? 0 : tp+1
  - decrement: tp = (tp == 0) ? DEPTH-1 : tp-1
  - No reliance on power-of-2 wrap.
- Per-cycle priority: flush_i > (push_i & pop_i) > push_i > pop_i.
- flush_i:
  - count = 0, tp = 0, overflow_o next = 0.
  - Entry contents untouched.
  - Concurrent push/pop ignored.
- push_i & pop_i:
  - count > 0: replace in place, entry[tp] = data_i; tp and count unchanged; no overflow.
  - count == 0: behaves exactly as push_i alone.
- push_i only:
  - tp = inc(tp); entry[inc(tp)] = data_i.
  - count < DEPTH: count+1, overflow_o next = 0.
  - count == DEPTH: count stays DEPTH, oldest entry silently overwritten, overflow_o next = 1.
- pop_i only:
  - count > 0: tp = dec(tp), count-1.
  - count == 0: ignored; no state change (underflow is harmless).
- No request: state held; overflow_o next = 0.
- DEPTH = 1:
  - tp is constant 0.
  - Push always overwrites entry[0]; overflow pulses when count was already 1.

Test Plan:
- Reset, then DEPTH=2, push 0x100, push 0x200 on consecutive cycles → ra_o 0x200, count_o 2, valid_o 1, overflow_o 0; pop → ra_o 0x100, count_o 1; pop → valid_o 0, count_o 0.
- Overflow, DEPTH=2: push 0x10, 0x20, 0x30 → overflow_o high only in the cycle after the 0x30 push; count_o 2; pops yield 0x30 then 0x20, then valid_o 0.
- Simultaneous push+pop with top 0x40, count 1 → ra_o 0x44, count_o 1; on an empty stack, push+pop of 0x50 → ra_o 0x50, count_o 1.
- Underflow: pop on empty stack three times → count_o stays 0, valid_o 0; subsequent push 0x60 → ra_o 0x60, count_o 1.
- Flush: with count_o 2, assert flush_i together with push_i of 0x70 → count_o 0, valid_o 0, overflow_o 0; next push 0x80 → ra_o 0x80, count_o 1.
- Non-power-of-2, DEPTH=3: push 1,2,3,4 → overflow after the 4th push; pops return 4,3,2, then empty. Also assert rst_ni low asynchronously mid-push → outputs zero before the next clock edge.
